// File: rtl/ula_serial_ctrl.sv
// ula_serial_ctrl: bit-serial sequencer for a single external 1-bit ALU slice.
// Operands are streamed LSB-first into the slice, one bit per cycle, with the
// slice carry-out fed back as the next carry-in. After W cycles the assembled
// result and the ZERO/OVERFLOW/CARRYOUT flags are presented with a DONE pulse.
module ula_serial_ctrl #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         START,
    input  logic [W-1:0] OPA,
    input  logic [W-1:0] OPB,
    input  logic [3:0]   ALUCTL,
    output logic         BUSY,
    output logic         DONE,
    output logic [W-1:0] RESULT,
    output logic         ZERO,
    output logic         OVERFLOW,
    output logic         CARRYOUT,
    output logic         SL_A,
    output logic         SL_B,
    output logic         SL_AIN,
    output logic         SL_BIN,
    output logic         SL_CIN,
    output logic         SL_LESS,
    output logic [1:0]   SL_OPERATION,
    input  logic         SL_RESULT,
    input  logic         SL_COUT
);

    localparam int IW = (W > 1) ? $clog2(W) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [IW-1:0] IDX_ZERO = IW'(0);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t         state_r;
    state_t         state_next_s;
    logic           accept_s;
    logic           last_s;

    logic [W-1:0]   a_r;
    logic [W-1:0]   b_r;
    logic [3:0]     ctl_r;
    logic [IW-1:0]  idx_r;
    logic           carry_r;
    logic [W-1:0]   res_r;

    logic [W-1:0]   result_r;
    logic           zero_r;
    logic           ovf_r;
    logic           cout_r;
    logic           done_r;

    logic [W-1:0]   res_shift_s;
    logic [W-1:0]   result_next_s;
    logic           ovf_bit_s;
    logic           set_s;
    logic           add_op_s;
    logic           slt_op_s;

    // Next-state decode: accept in IDLE on START, leave RUN after the last bit.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        last_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (START) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (idx_r == LAST_IDX) begin
                    last_s       = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Result assembly: shifted partial result, or the overflow-corrected sign for SLT.
    always_comb begin
        res_shift_s   = {SL_RESULT, res_r[W-1:1]};
        ovf_bit_s     = carry_r ^ SL_COUT;
        set_s         = SL_RESULT ^ ovf_bit_s;
        add_op_s      = ctl_r[1];
        slt_op_s      = (ctl_r[1:0] == 2'b11);
        result_next_s = res_shift_s;
        if (slt_op_s) begin
            result_next_s = {{(W-1){1'b0}}, set_s};
        end else begin
            result_next_s = res_shift_s;
        end
    end

    // Slice drive: current operand bits and latched controls in RUN, all zero in IDLE.
    always_comb begin
        SL_A         = 1'b0;
        SL_B         = 1'b0;
        SL_AIN       = 1'b0;
        SL_BIN       = 1'b0;
        SL_CIN       = 1'b0;
        SL_OPERATION = 2'b00;
        if (state_r == ST_RUN) begin
            SL_A   = a_r[idx_r];
            SL_B   = b_r[idx_r];
            SL_AIN = ctl_r[3];
            SL_BIN = ctl_r[2];
            SL_CIN = carry_r;
            // The slice LESS path is unused: SLT runs the adder and fixes the sign here.
            if (ctl_r[1:0] == 2'b11) begin
                SL_OPERATION = 2'b10;
            end else begin
                SL_OPERATION = ctl_r[1:0];
            end
        end else begin
            SL_OPERATION = 2'b00;
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand latch and per-bit sequencing (carry feedback, result shift, bit index).
    always_ff @(posedge CLK) begin
        if (RESET) begin
            a_r     <= {W{1'b0}};
            b_r     <= {W{1'b0}};
            ctl_r   <= 4'b0000;
            idx_r   <= IDX_ZERO;
            carry_r <= 1'b0;
            res_r   <= {W{1'b0}};
        end else if (accept_s) begin
            a_r     <= OPA;
            b_r     <= OPB;
            ctl_r   <= ALUCTL;
            idx_r   <= IDX_ZERO;
            carry_r <= ALUCTL[2];
            res_r   <= {W{1'b0}};
        end else if (state_r == ST_RUN) begin
            carry_r <= SL_COUT;
            res_r   <= res_shift_s;
            idx_r   <= idx_r + IDX_ONE;
        end else begin
            carry_r <= carry_r;
        end
    end

    // Output registers: result and flags update only on the last bit; DONE pulses once.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            result_r <= {W{1'b0}};
            zero_r   <= 1'b0;
            ovf_r    <= 1'b0;
            cout_r   <= 1'b0;
            done_r   <= 1'b0;
        end else if (last_s) begin
            done_r   <= 1'b1;
            result_r <= result_next_s;
            zero_r   <= (result_next_s == {W{1'b0}});
            if (add_op_s) begin
                ovf_r  <= ovf_bit_s;
                cout_r <= SL_COUT;
            end else begin
                ovf_r  <= 1'b0;
                cout_r <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign BUSY     = (state_r == ST_RUN);
    assign DONE     = done_r;
    assign RESULT   = result_r;
    assign ZERO     = zero_r;
    assign OVERFLOW = ovf_r;
    assign CARRYOUT = cout_r;
    assign SL_LESS  = 1'b0;

endmodule

// File: tb/tb_ula_serial_ctrl.sv
// tb_ula_serial_ctrl: directed-vector bench with a 1-bit ALU slice model behind
// the SL_* ports. Stimulus pushes hand-computed results into a scoreboard queue;
// a monitor pops and compares on every DONE pulse.
module tb_ula_serial_ctrl;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         START;
    logic [W-1:0] OPA;
    logic [W-1:0] OPB;
    logic [3:0]   ALUCTL;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] RESULT;
    logic         ZERO;
    logic         OVERFLOW;
    logic         CARRYOUT;
    logic         SL_A;
    logic         SL_B;
    logic         SL_AIN;
    logic         SL_BIN;
    logic         SL_CIN;
    logic         SL_LESS;
    logic [1:0]   SL_OPERATION;
    logic         SL_RESULT;
    logic         SL_COUT;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int busy_cnt  = 0;

    typedef struct {
        string        name;
        logic [W-1:0] res;
        logic         z;
        logic         o;
        logic         c;
    } exp_t;

    exp_t sb[$];

    ula_serial_ctrl #(.W(W)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .OPA(OPA), .OPB(OPB), .ALUCTL(ALUCTL),
        .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .ZERO(ZERO), .OVERFLOW(OVERFLOW),
        .CARRYOUT(CARRYOUT), .SL_A(SL_A), .SL_B(SL_B), .SL_AIN(SL_AIN), .SL_BIN(SL_BIN),
        .SL_CIN(SL_CIN), .SL_LESS(SL_LESS), .SL_OPERATION(SL_OPERATION),
        .SL_RESULT(SL_RESULT), .SL_COUT(SL_COUT)
    );

    always #5 CLK = ~CLK;

    // 1-bit ALU slice: optional input inversion, AND/OR/ADD/LESS, full-adder carry.
    logic a_eff;
    logic b_eff;
    always_comb begin
        a_eff   = SL_A ^ SL_AIN;
        b_eff   = SL_B ^ SL_BIN;
        SL_COUT = (a_eff & b_eff) | (a_eff & SL_CIN) | (b_eff & SL_CIN);
        case (SL_OPERATION)
            2'b00:   SL_RESULT = a_eff & b_eff;
            2'b01:   SL_RESULT = a_eff | b_eff;
            2'b10:   SL_RESULT = a_eff ^ b_eff ^ SL_CIN;
            default: SL_RESULT = SL_LESS;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: count RUN cycles and compare each DONE against the scoreboard head.
    always @(negedge CLK) begin
        if (RESET) begin
            busy_cnt = 0;
        end else if (DONE) begin
            exp_t e;
            check("busy_low_at_done", {31'd0, BUSY}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check({e.name, "_latency"},  busy_cnt,          32'd8);
                check({e.name, "_result"},   {24'd0, RESULT},   {24'd0, e.res});
                check({e.name, "_zero"},     {31'd0, ZERO},     {31'd0, e.z});
                check({e.name, "_overflow"}, {31'd0, OVERFLOW}, {31'd0, e.o});
                check({e.name, "_carryout"}, {31'd0, CARRYOUT}, {31'd0, e.c});
            end
            busy_cnt = 0;
        end else if (BUSY) begin
            busy_cnt++;
        end
    end

    // Drive one accepted request at the current negedge; optionally record its expectation.
    task automatic issue(input string name, input logic [3:0] ctl, input logic [7:0] a,
                         input logic [7:0] b, input bit push, input logic [7:0] res,
                         input logic z, input logic o, input logic c);
        exp_t e;
        START  = 1'b1;
        ALUCTL = ctl;
        OPA    = a;
        OPB    = b;
        if (push) begin
            e.name = name; e.res = res; e.z = z; e.o = o; e.c = c;
            sb.push_back(e);
        end
        @(negedge CLK);
        START = 1'b0;
    endtask

    // Wait (bounded) for a DONE pulse; returns at the negedge where DONE is high.
    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (DONE) begin
                seen = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        if (!seen) begin
            check({name, "_done_timeout"}, 32'd1, 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        RESET = 1'b1; START = 1'b0; OPA = 8'h00; OPB = 8'h00; ALUCTL = 4'b0000;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        check("reset_outputs",
              {16'd0, BUSY, DONE, RESULT, ZERO, OVERFLOW, CARRYOUT, SL_A, SL_B, SL_CIN},
              32'd0);
        check("reset_slice_ctl", {27'd0, SL_AIN, SL_BIN, SL_LESS, SL_OPERATION}, 32'd0);

        // Function vectors, each run to completion.
        issue("and",   4'b0000, 8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0); wait_done("and");
        @(negedge CLK);
        issue("add",   4'b0010, 8'hFF, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1); wait_done("add");
        @(negedge CLK);
        issue("sub",   4'b0110, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b1); wait_done("sub");
        @(negedge CLK);
        issue("nor",   4'b1100, 8'h0F, 8'h30, 1'b1, 8'hC0, 1'b0, 1'b0, 1'b0); wait_done("nor");
        @(negedge CLK);
        issue("slt_a", 4'b0111, 8'h80, 8'h01, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1); wait_done("slt_a");
        @(negedge CLK);
        issue("slt_b", 4'b0111, 8'h05, 8'h03, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1); wait_done("slt_b");
        @(negedge CLK);
        check("result_held", {24'd0, RESULT}, 32'd0);
        check("idle_slice_a", {31'd0, SL_A}, 32'd0);

        // START pulsed mid-RUN with different operands must be ignored.
        issue("add_keep", 4'b0010, 8'h12, 8'h34, 1'b1, 8'h46, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge CLK);
        issue("ignored", 4'b0010, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        wait_done("add_keep");

        // Back-to-back: a new request in the DONE cycle is accepted.
        @(negedge CLK);
        issue("add_ovf", 4'b0010, 8'h01, 8'h7F, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0);
        wait_done("add_ovf");
        issue("or_b2b", 4'b0001, 8'hA0, 8'h05, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        check("b2b_busy", {31'd0, BUSY}, 32'd1);
        wait_done("or_b2b");

        // Reset after three RUN cycles aborts the operation and clears all outputs.
        @(negedge CLK);
        issue("aborted", 4'b0010, 8'h11, 8'h22, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check("abort_outputs",
              {16'd0, BUSY, DONE, RESULT, ZERO, OVERFLOW, CARRYOUT, SL_A, SL_B, SL_CIN},
              32'd0);
        check("abort_slice_ctl", {27'd0, SL_AIN, SL_BIN, SL_LESS, SL_OPERATION}, 32'd0);
        @(negedge CLK);
        check("abort_no_done", {31'd0, DONE}, 32'd0);
        issue("add_fresh", 4'b0010, 8'h01, 8'h01, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
        wait_done("add_fresh");

        repeat (3) @(negedge CLK);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
